// File: rtl/uart_buf_pkg.sv
// ============================================================================
// Module      : uart_buf_pkg
// Description : Shared defaults, width helper and status bundle for the UART
//               receive holding buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_buf_pkg;

    localparam int unsigned c_def_data_w   = 8;
    localparam int unsigned c_def_depth    = 16;
    localparam int unsigned c_def_af_level = 12;

    // Ceiling log2 evaluated at elaboration time for pointer and count widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
        logic underflow;
    } status_t;

endpackage

`default_nettype wire

// File: rtl/uart_buf_mem.sv
// ============================================================================
// Module      : uart_buf_mem
// Description : DEPTH x DATA_W storage with one clocked write port and one
//               asynchronous read port. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_buf_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module      : uart_rx_buffer
// Description : First-word-fall-through receive FIFO with fill level and
//               sticky overflow/underflow flags. Define
//               UART_RX_BUFFER_OVERWRITE_EN to make a push into a full buffer
//               replace the oldest entry instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer
    import uart_buf_pkg::*;
#(
    parameter int unsigned DATA_W   = c_def_data_w,
    parameter int unsigned DEPTH    = c_def_depth,
    parameter int unsigned AF_LEVEL = c_def_af_level
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  flush
);

    localparam int unsigned c_ptr_w = clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_LEVEL);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               w_is_empty;
    logic               w_is_full;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_mem_rd;
    status_t            w_status;

    assign w_is_empty = (count_q == '0);
    assign w_is_full  = (count_q == c_full_cnt);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        w_push_ok   = 1'b0;
        w_pop_ok    = 1'b0;
        w_mem_we    = 1'b0;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            w_pop_ok  = pop && !w_is_empty;
            // A pop in the same cycle frees the slot, so a full buffer still accepts.
            w_push_ok = push && (!w_is_full || pop);

            if (pop && w_is_empty) begin
                underflow_d = 1'b1;
            end

            if (push && w_is_full && !pop) begin
                overflow_d = 1'b1;
`ifdef UART_RX_BUFFER_OVERWRITE_EN
                // wr_ptr equals rd_ptr here: replace the oldest and advance both.
                w_mem_we = 1'b1;
                wr_ptr_d = wr_ptr_q + c_ptr_one;
                rd_ptr_d = rd_ptr_q + c_ptr_one;
`endif
            end

            if (w_push_ok) begin
                w_mem_we = 1'b1;
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end

            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end

            case ({w_push_ok, w_pop_ok})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    uart_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (w_mem_rd)
    );

    always_comb begin
        w_status.empty       = w_is_empty;
        w_status.full        = w_is_full;
        w_status.almost_full = (count_q >= c_af_cnt);
        w_status.overflow    = overflow_q;
        w_status.underflow   = underflow_q;
    end

    // Stale storage is masked so an empty buffer always reads as zero.
    assign rd_data     = w_is_empty ? '0 : w_mem_rd;
    assign empty       = w_status.empty;
    assign full        = w_status.full;
    assign almost_full = w_status.almost_full;
    assign overflow    = w_status.overflow;
    assign underflow   = w_status.underflow;
    assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Scoreboard bench for uart_rx_buffer (DATA_W=8, DEPTH=4,
//               AF_LEVEL=3) with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

    localparam int unsigned c_data_w = 8;
    localparam int unsigned c_depth  = 4;
    localparam int unsigned c_af     = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                push;
    logic                pop;
    logic                flush;
    logic [c_data_w-1:0] wr_data;
    logic [c_data_w-1:0] rd_data;
    logic                empty;
    logic                full;
    logic                almost_full;
    logic [2:0]          count;
    logic                overflow;
    logic                underflow;

    uart_rx_buffer #(
        .DATA_W   (c_data_w),
        .DEPTH    (c_depth),
        .AF_LEVEL (c_af)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .wr_data     (wr_data),
        .pop         (pop),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [c_data_w-1:0] model_q [$];
    logic                m_ovf = 1'b0;
    logic                m_udf = 1'b0;
    logic [c_data_w-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: a bounded queue with sticky error bits.
    function automatic void model_update(input logic p, input logic [c_data_w-1:0] d,
                                         input logic o, input logic f);
        bit was_empty;
        bit was_full;
        logic [c_data_w-1:0] dropped;
        if (f) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        was_empty = (model_q.size() == 0);
        was_full  = (model_q.size() == c_depth);
        if (o && was_empty) m_udf = 1'b1;
        if (p && was_full && !o) begin
            m_ovf = 1'b1;
`ifdef UART_RX_BUFFER_OVERWRITE_EN
            dropped = model_q.pop_front();
            model_q.push_back(d);
`endif
        end else begin
            if (o && !was_empty) dropped = model_q.pop_front();
            if (p) model_q.push_back(d);
        end
    endfunction

    task automatic check_status(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"},       32'(count),       32'(sz));
        chk({tag, ".empty"},       32'(empty),       32'(sz == 0));
        chk({tag, ".full"},        32'(full),        32'(sz == c_depth));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= c_af));
        chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk({tag, ".underflow"},   32'(underflow),   32'(m_udf));
        chk({tag, ".rd_data"},     32'(rd_data),     (sz == 0) ? 32'd0 : 32'(model_q[0]));
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input string tag, input logic p, input logic [c_data_w-1:0] d,
                        input logic o, input logic f);
        push    = p;
        wr_data = d;
        pop     = o;
        flush   = f;
        if (!f && o && model_q.size() != 0) exp_q.push_back(model_q[0]);
        @(posedge clk);
        model_update(p, d, o, f);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        wr_data = 8'($urandom);
        check_status(tag);
    endtask

    // Monitor: every accepted read the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && pop && !flush && !empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_read: got 0x%0h expected no read", rd_data);
            end else begin
                chk("pop_read", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        push    = 1'b1;
        pop     = 1'b0;
        flush   = 1'b0;
        wr_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        reset = 1'b0;
        push  = 1'b0;

        // Basic fill and drain
        step("t1_push", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("t1_push", 1'b1, 8'hB2, 1'b0, 1'b0);
        step("t1_push", 1'b1, 8'hC3, 1'b0, 1'b0);
        repeat (3) step("t1_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Push into a full buffer without pop
        for (int i = 0; i < 4; i++) step("t2_fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("t2_ovf", 1'b1, 8'h14, 1'b0, 1'b0);
        repeat (4) step("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step("t3_fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("t3_pp", 1'b1, 8'h55, 1'b1, 1'b0);
        repeat (4) step("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with simultaneous push and pop
        step("t4_pp", 1'b1, 8'h7E, 1'b1, 1'b0);
        step("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap
        for (int i = 0; i < 6; i++) begin
            step("t5_push", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            step("t5_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Flush beats push/pop
        step("t6_push", 1'b1, 8'h41, 1'b0, 1'b0);
        step("t6_push", 1'b1, 8'h42, 1'b0, 1'b0);
        step("t6_flush", 1'b1, 8'h43, 1'b1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic p, o, f;
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 49) == 0);
            step("rand", p, 8'($urandom), o, f);
        end

        // Asynchronous reset between edges, mid-burst, with sticky flags set
        step("t6_flush2", 1'b0, 8'h00, 1'b0, 1'b1);
        step("t6_udf", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("t6_burst", 1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        step("t6_ovf", 1'b1, 8'h29, 1'b0, 1'b0);
        push    = 1'b1;
        wr_data = 8'h2A;
        #3;
        reset = 1'b1;
        push  = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_status("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
        step("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
